// File: rtl/memory_turn_ctrl.sv
// Memory-game turn controller: takes two card picks, reads both faces, scores the pair.
// Outputs registered; pair result lands 3 cycles after the 2nd pick; pick_ready low except between turns/picks.
module memory_turn_ctrl #(
  parameter int N_CARDS    = 16,
  parameter int HOLD_TICKS = 60
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        new_game,
  input  logic        pick_valid,
  input  logic [3:0]  pick_idx,
  output logic        pick_ready,
  output logic [3:0]  card_addr,
  input  logic [2:0]  card_val,
  output logic [15:0] face_up,
  output logic [15:0] matched,
  output logic [3:0]  pairs,
  output logic [7:0]  misses,
  output logic        game_over
);

  typedef enum logic [2:0] {IDLE, RD1, WAIT2, RD2, CMP, HOLD, DONE} state_t;

  localparam logic [4:0] CARD_LIM  = 5'(N_CARDS);
  localparam logic [3:0] PAIR_LIM  = 4'(N_CARDS / 2);
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_TICKS);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] idx1;
  logic [3:0] idx2;
  logic [2:0] val1;
  logic [2:0] val2;
  logic [7:0] hold_cnt;
  logic       pick_ok;
  logic       vals_eq;
  logic       last_pair;
  logic       hold_done;

  // new_game suppresses a same-cycle pick so the fresh board starts clean
  assign pick_ok   = pick_valid && pick_ready && ({1'b0, pick_idx} < CARD_LIM) &&
                     !face_up[pick_idx] && !matched[pick_idx] && !new_game;
  assign vals_eq   = (val1 == val2);
  assign last_pair = ((pairs + 4'd1) == PAIR_LIM);
  assign hold_done = frame_tick && (hold_cnt <= 8'd1);

  always_ff @(posedge pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_ok) state_nxt = RD1;
      RD1:     state_nxt = WAIT2;
      WAIT2:   if (pick_ok) state_nxt = RD2;
      RD2:     state_nxt = CMP;
      CMP:     state_nxt = vals_eq ? (last_pair ? DONE : IDLE) : HOLD;
      HOLD:    if (hold_done) state_nxt = IDLE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (new_game) state_nxt = IDLE;
  end

  always_comb begin
    pick_ready = (state == IDLE) || (state == WAIT2);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      face_up   <= '0;
      matched   <= '0;
      pairs     <= '0;
      misses    <= '0;
      card_addr <= '0;
      game_over <= 1'b0;
      hold_cnt  <= '0;
      idx1      <= '0;
      idx2      <= '0;
      val1      <= '0;
      val2      <= '0;
    end else if (new_game) begin
      face_up   <= '0;
      matched   <= '0;
      pairs     <= '0;
      misses    <= '0;
      card_addr <= '0;
      game_over <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      game_over <= (state_nxt == DONE);
      case (state)
        IDLE, WAIT2: begin
          if (pick_ok) begin
            card_addr          <= pick_idx;
            face_up[pick_idx]  <= 1'b1;
            if (state == IDLE) idx1 <= pick_idx;
            else               idx2 <= pick_idx;
          end
        end
        RD1: val1 <= card_val;
        RD2: val2 <= card_val;
        CMP: begin
          if (vals_eq) begin
            face_up[idx1] <= 1'b0;
            face_up[idx2] <= 1'b0;
            matched[idx1] <= 1'b1;
            matched[idx2] <= 1'b1;
            pairs         <= pairs + 4'd1;
          end else begin
            if (misses != 8'hFF) misses <= misses + 8'd1;
            hold_cnt <= HOLD_INIT;
          end
        end
        HOLD: begin
          if (frame_tick) begin
            hold_cnt <= hold_cnt - 8'd1;
            if (hold_done) begin
              face_up[idx1] <= 1'b0;
              face_up[idx2] <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_turn_ctrl.sv
// Bench for memory_turn_ctrl: directed turns plus random picks against a turn-level reference model.
module tb_memory_turn_ctrl;

  localparam int NC = 12;
  localparam int HT = 3;

  logic        pclk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        new_game;
  logic        pick_valid;
  logic [3:0]  pick_idx;
  logic        pick_ready;
  logic [3:0]  card_addr;
  logic [2:0]  card_val;
  logic [15:0] face_up;
  logic [15:0] matched;
  logic [3:0]  pairs;
  logic [7:0]  misses;
  logic        game_over;

  logic [2:0]  tbl [16];
  int          n_checks = 0;
  int          n_errors = 0;

  // reference model of the board and the turn in progress
  logic [15:0] m_face    = '0;
  logic [15:0] m_matched = '0;
  logic [3:0]  m_pairs   = '0;
  logic [7:0]  m_misses  = '0;
  logic [3:0]  m_addr    = '0;
  logic        m_done    = 1'b0;
  int          m_busy    = 0;
  int          m_hold    = 0;
  int          m_sel1    = -1;
  int          m_sel2    = -1;

  memory_turn_ctrl #(.N_CARDS(NC), .HOLD_TICKS(HT)) dut (
    .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .new_game(new_game),
    .pick_valid(pick_valid), .pick_idx(pick_idx), .pick_ready(pick_ready),
    .card_addr(card_addr), .card_val(card_val), .face_up(face_up),
    .matched(matched), .pairs(pairs), .misses(misses), .game_over(game_over)
  );

  always #5 pclk = ~pclk;
  assign card_val = tbl[card_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_rdy();
    return !m_done && (m_hold == 0) && (m_busy == 0);
  endfunction

  task automatic m_clear();
    m_face = '0; m_matched = '0; m_pairs = '0; m_misses = '0; m_addr = '0;
    m_done = 1'b0; m_busy = 0; m_hold = 0; m_sel1 = -1; m_sel2 = -1;
  endtask

  task automatic m_resolve();
    if (tbl[m_sel1] == tbl[m_sel2]) begin
      m_matched[m_sel1] = 1'b1;
      m_matched[m_sel2] = 1'b1;
      m_face  = '0;
      m_pairs = m_pairs + 4'd1;
      if (int'(m_pairs) == NC / 2) m_done = 1'b1;
      m_sel1 = -1;
      m_sel2 = -1;
    end else begin
      if (m_misses != 8'd255) m_misses = m_misses + 8'd1;
      m_hold = HT;
    end
  endtask

  task automatic model_step(input logic r, input logic ng, input logic pv,
                            input logic [3:0] pi, input logic ft);
    logic rdy;
    rdy = m_rdy();
    if (r || ng) begin
      m_clear();
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0 && m_sel2 >= 0) m_resolve();
    end else if (m_hold > 0) begin
      if (ft) begin
        m_hold--;
        if (m_hold == 0) begin
          m_face = '0;
          m_sel1 = -1;
          m_sel2 = -1;
        end
      end
    end else if (rdy && pv && int'(pi) < NC && !m_face[pi] && !m_matched[pi]) begin
      m_face[pi] = 1'b1;
      m_addr = pi;
      if (m_sel1 < 0) begin
        m_sel1 = int'(pi);
        m_busy = 1;
      end else begin
        m_sel2 = int'(pi);
        m_busy = 2;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic ng, input logic pv,
                     input logic [3:0] pi, input logic ft);
    rst = r; new_game = ng; pick_valid = pv; pick_idx = pi; frame_tick = ft;
    @(posedge pclk);
    model_step(r, ng, pv, pi, ft);
    #1;
    chk("outs", {14'b0, pick_ready, game_over, pairs, misses, card_addr, matched, face_up},
                {14'b0, m_rdy(), m_done, m_pairs, m_misses, m_addr, m_matched, m_face});
    chk("face_cnt", 64'($countones(face_up) <= 2), 64'd1);
    rst = 1'b0; new_game = 1'b0; pick_valid = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic idle();              cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0); endtask
  task automatic pick(input logic [3:0] i); cyc(1'b0, 1'b0, 1'b1, i, 1'b0); endtask
  task automatic tick();              cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1); endtask

  task automatic turn(input logic [3:0] a, input logic [3:0] b);
    pick(a);
    idle();
    pick(b);
    idle();
    idle();
    for (int k = 0; k < 10 && m_hold > 0; k++) begin
      idle();
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; new_game = 1'b0; pick_valid = 1'b0; pick_idx = '0; frame_tick = 1'b0;
    for (int i = 0; i < 16; i++) tbl[i] = 3'(i);
    tbl[0] = 3'd3; tbl[5] = 3'd3; tbl[3] = 3'd6;

    // reset state
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    idle();
    chk("rst_state", {pairs, misses, card_addr, matched, face_up, game_over}, 64'd0);
    chk("rst_rdy", pick_ready, 1'b1);

    // matching pair 0/5
    pick(4'd0);
    chk("m_face1", face_up, 16'h0001);
    chk("m_rd1_rdy", pick_ready, 1'b0);
    idle();
    pick(4'd5);
    idle();
    idle();
    chk("m_matched", matched, 16'h0021);
    chk("m_face", face_up, 16'h0000);
    chk("m_pairs", pairs, 4'd1);
    chk("m_misses", misses, 8'd0);
    pick(4'd0);
    chk("m_repick", face_up, 16'h0000);

    // mismatch with illegal picks along the way
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("ng_clear", {matched, pairs}, 64'd0);
    tbl[0] = 3'd1; tbl[1] = 3'd2;
    pick(4'd0);
    pick(4'd3);
    chk("x_rd1", face_up, 16'h0001);
    pick(4'd0);
    chk("x_same", face_up, 16'h0001);
    chk("x_same_rdy", pick_ready, 1'b1);
    pick(4'(NC));
    chk("x_range", face_up, 16'h0001);
    pick(4'd1);
    idle();
    idle();
    chk("x_hold_face", face_up, 16'h0003);
    chk("x_misses", misses, 8'd1);
    chk("x_hold_rdy", pick_ready, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 4'd4, 1'b1);
    chk("x_tick1", face_up, 16'h0003);
    idle();
    tick();
    chk("x_tick2", face_up, 16'h0003);
    chk("x_tick2_rdy", pick_ready, 1'b0);
    idle();
    cyc(1'b0, 1'b0, 1'b1, 4'd5, 1'b1);
    chk("x_tick3", face_up, 16'h0000);
    chk("x_tick3_rdy", pick_ready, 1'b1);

    // new_game mid-hold beats a same-cycle pick
    pick(4'd0); idle(); pick(4'd1); idle(); idle(); tick();
    cyc(1'b0, 1'b1, 1'b1, 4'd2, 1'b0);
    chk("nh_state", {pairs, misses, card_addr, matched, face_up, game_over}, 64'd0);
    chk("nh_rdy", pick_ready, 1'b1);
    idle();
    chk("nh_face", face_up, 16'h0000);

    // full game
    for (int i = 0; i < 16; i++) tbl[i] = 3'(i % 6);
    for (int i = 0; i < NC / 2; i++) turn(4'(i), 4'(i + NC / 2));
    chk("g_over", game_over, 1'b1);
    chk("g_matched", matched, 16'h0FFF);
    chk("g_pairs", pairs, 4'd6);
    chk("g_rdy", pick_ready, 1'b0);
    pick(4'd12);
    idle();
    chk("g_frozen", {face_up, matched, 7'b0, game_over}, {16'h0000, 16'h0FFF, 8'h01});

    // misses saturate
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    tbl[0] = 3'd1; tbl[1] = 3'd2;
    for (int t = 0; t < 256; t++) turn(4'd0, 4'd1);
    chk("sat_misses", misses, 8'd255);

    // reset mid-hold and mid-read aborts the turn
    pick(4'd0); idle(); pick(4'd1); idle(); idle();
    cyc(1'b1, 1'b0, 1'b1, 4'd2, 1'b1);
    chk("rh_state", {pairs, misses, face_up}, 64'd0);
    pick(4'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("rr_face", face_up, 16'h0000);
    chk("rr_rdy", pick_ready, 1'b1);

    // random play
    for (int p = 0; p < NC / 2; p++) begin
      tbl[2 * p] = 3'(p + 1);
      tbl[2 * p + 1] = 3'(p + 1);
    end
    for (int i = NC - 1; i > 0; i--) begin
      int j;
      logic [2:0] tv;
      j = $urandom_range(0, i);
      tv = tbl[i]; tbl[i] = tbl[j]; tbl[j] = tv;
    end
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    for (int c = 0; c < 4000; c++) begin
      logic r, ng, pv, ft;
      logic [3:0] pi;
      r  = ($urandom_range(0, 799) == 0);
      ng = ($urandom_range(0, 999) == 0);
      pv = ($urandom_range(0, 1) == 1);
      pi = 4'($urandom_range(0, 15));
      ft = ($urandom_range(0, 3) == 0);
      cyc(r, ng, pv, pi, ft);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
